// File: rtl/nibble_serial_alu_ctrl.sv
// nibble_serial_alu_ctrl
//
// Low-area WIDTH-bit adder/subtractor. A single 4-bit ripple-carry adder is
// reused over WIDTH/4 consecutive cycles, LSB nibble first, with the nibble
// carry held in a register between cycles. Subtraction is A + ~B + 1: B is
// inverted at accept time and the carry register starts at 1.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start_valid/ready request handshake; ready only while idle
//   a, b, sub         operands and op select, sampled on accept only
//   res_valid/ready   result handshake; valid only while holding a result
//   result            sum/difference modulo 2^WIDTH
//   carry_out         carry out of the MSB (for subtract: 1 = no borrow)
//   overflow          signed two's-complement overflow
//   zero              result == 0
//   busy              operation in flight or result waiting
//
// WIDTH must be a multiple of 4 and at least 8.
// Every output comes straight from a flop; there is no input-to-output path.

module nibble_serial_alu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q,       state_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic             carry_q,       carry_d;
    logic [WIDTH-1:0] opa_q,         opa_d;
    logic [WIDTH-1:0] opb_q,         opb_d;
    logic [WIDTH-1:0] result_q,      result_d;
    logic             carry_out_q,   carry_out_d;
    logic             overflow_q,    overflow_d;
    logic             zero_q,        zero_d;
    logic             start_ready_q, start_ready_d;
    logic             res_valid_q,   res_valid_d;
    logic             busy_q,        busy_d;

    // Shared nibble adder, fed by the nibble selected by cnt_q.
    logic [CNT_W+1:0] nib_base;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_sum;
    logic             nib_co;
    logic [WIDTH-1:0] result_nxt;

    always_comb begin
        nib_base          = {cnt_q, 2'b00};
        nib_a             = opa_q[nib_base +: 4];
        nib_b             = opb_q[nib_base +: 4];
        {nib_co, nib_sum} = {1'b0, nib_a} + {1'b0, nib_b} + {4'd0, carry_q};
        // Result with the current nibble merged in; the flags on the final
        // edge must see the last nibble, so they are computed from this.
        result_nxt                = result_q;
        result_nxt[nib_base +: 4] = nib_sum;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        carry_d       = carry_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        result_d      = result_q;
        carry_out_d   = carry_out_q;
        overflow_d    = overflow_q;
        zero_d        = zero_q;
        start_ready_d = start_ready_q;
        res_valid_d   = res_valid_q;
        busy_d        = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    opa_d         = a;
                    opb_d         = sub ? ~b : b;
                    carry_d       = sub;
                    cnt_d         = '0;
                    state_d       = ST_RUN;
                    start_ready_d = 1'b0;
                    busy_d        = 1'b1;
                end
            end
            ST_RUN: begin
                result_d = result_nxt;
                carry_d  = nib_co;
                if (cnt_q == LAST_NIB) begin
                    // Last nibble: do not advance cnt so it never wraps.
                    state_d     = ST_DONE;
                    carry_out_d = nib_co;
                    overflow_d  = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                                  (result_nxt[WIDTH-1] != opa_q[WIDTH-1]);
                    zero_d      = (result_nxt == '0);
                    res_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                // Return to idle only; a new request is taken next cycle.
                if (res_ready) begin
                    state_d       = ST_IDLE;
                    res_valid_d   = 1'b0;
                    busy_d        = 1'b0;
                    start_ready_d = 1'b1;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                res_valid_d   = 1'b0;
                busy_d        = 1'b0;
                start_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            carry_q       <= 1'b0;
            opa_q         <= '0;
            opb_q         <= '0;
            result_q      <= '0;
            carry_out_q   <= 1'b0;
            overflow_q    <= 1'b0;
            zero_q        <= 1'b0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            carry_q       <= carry_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            result_q      <= result_d;
            carry_out_q   <= carry_out_d;
            overflow_q    <= overflow_d;
            zero_q        <= zero_d;
            start_ready_q <= start_ready_d;
            res_valid_q   <= res_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign start_ready = start_ready_q;
    assign res_valid   = res_valid_q;
    assign busy        = busy_q;
    assign result      = result_q;
    assign carry_out   = carry_out_q;
    assign overflow    = overflow_q;
    assign zero        = zero_q;

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
module tb_nibble_serial_alu_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sv32 = 0, rr32 = 0, sub32 = 0;
    logic [31:0] a32 = 0, b32 = 0;
    logic        sr32, rv32, c32, v32, z32, bz32;
    logic [31:0] res32;

    logic        sv8 = 0, rr8 = 0, sub8 = 0;
    logic [7:0]  a8 = 0, b8 = 0;
    logic        sr8, rv8, c8, v8, z8, bz8;
    logic [7:0]  res8;

    nibble_serial_alu_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv32), .start_ready(sr32),
        .a(a32), .b(b32), .sub(sub32), .res_valid(rv32), .res_ready(rr32),
        .result(res32), .carry_out(c32), .overflow(v32), .zero(z32), .busy(bz32)
    );

    nibble_serial_alu_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
        .a(a8), .b(b8), .sub(sub8), .res_valid(rv8), .res_ready(rr8),
        .result(res8), .carry_out(c8), .overflow(v8), .zero(z8), .busy(bz8)
    );

    int errs = 0;
    int checks = 0;

    typedef struct {
        logic sr, rv, busy;
        logic [31:0] res;
        logic c, v, z;
    } obs_t;

    typedef struct {
        bit          w8;
        logic [31:0] a, b;
        logic        s;
        logic [31:0] r;
        logic        c, v, z;
        string       nm;
    } vec_t;

    function automatic obs_t get(bit w8);
        obs_t o;
        if (w8) begin
            o.sr = sr8; o.rv = rv8; o.busy = bz8; o.res = {24'd0, res8};
            o.c = c8; o.v = v8; o.z = z8;
        end else begin
            o.sr = sr32; o.rv = rv32; o.busy = bz32; o.res = res32;
            o.c = c32; o.v = v32; o.z = z32;
        end
        return o;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_in(bit w8, logic sv, logic [31:0] a, logic [31:0] b, logic s);
        if (w8) begin sv8 = sv; a8 = a[7:0]; b8 = b[7:0]; sub8 = s; end
        else    begin sv32 = sv; a32 = a; b32 = b; sub32 = s; end
    endtask

    task automatic set_rr(bit w8, logic rr);
        if (w8) rr8 = rr; else rr32 = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the full operands.
    function automatic void model(input bit w8, input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output logic [31:0] r,
                                  output logic c, output logic v, output logic z);
        longint w, full, half, ua, ub, sa, sb, id;
        w    = w8 ? 8 : 32;
        full = longint'(1) << w;
        half = full / 2;
        ua   = longint'({32'd0, a}) & (full - 1);
        ub   = longint'({32'd0, b}) & (full - 1);
        sa   = (ua >= half) ? ua - full : ua;
        sb   = (ub >= half) ? ub - full : ub;
        id   = s ? sa - sb : sa + sb;
        v    = (id >= half) || (id < -half);
        c    = s ? (ua >= ub) : ((ua + ub) >= full);
        r    = 32'((s ? ua - ub : ua + ub) & (full - 1));
        z    = (r == 0);
    endfunction

    task automatic accept(bit w8, logic [31:0] a, logic [31:0] b, logic s);
        int n = 0;
        obs_t o;
        o = get(w8);
        while (!o.sr && n < 50) begin tick(); n++; o = get(w8); end
        chk("start_ready before accept", {31'd0, o.sr}, 32'd1);
        set_in(w8, 1'b1, a, b, s);
        tick();
        set_in(w8, 1'b0, $urandom, $urandom, 1'($urandom_range(1)));
        o = get(w8);
        chk("busy after accept", {31'd0, o.busy}, 32'd1);
        chk("start_ready low after accept", {31'd0, o.sr}, 32'd0);
    endtask

    // Called right after the accept edge: counts edges to res_valid.
    task automatic collect(bit w8, logic [31:0] er, logic ec, logic ev, logic ez,
                           string nm, int hold);
        int lat = 0;
        obs_t o;
        o = get(w8);
        while (!o.rv && lat < 100) begin tick(); lat++; o = get(w8); end
        chk({nm, " latency"}, lat, w8 ? 2 : 8);
        chk({nm, " result"}, o.res, er);
        chk({nm, " carry_out"}, {31'd0, o.c}, {31'd0, ec});
        chk({nm, " overflow"}, {31'd0, o.v}, {31'd0, ev});
        chk({nm, " zero"}, {31'd0, o.z}, {31'd0, ez});
        for (int h = 0; h < hold; h++) begin
            tick();
            o = get(w8);
            chk({nm, " held valid"}, {31'd0, o.rv}, 32'd1);
            chk({nm, " held result"}, o.res, er);
        end
        set_rr(w8, 1'b1);
        tick();
        set_rr(w8, 1'b0);
        o = get(w8);
        chk({nm, " valid after handshake"}, {31'd0, o.rv}, 32'd0);
        chk({nm, " busy after handshake"}, {31'd0, o.busy}, 32'd0);
        chk({nm, " ready after handshake"}, {31'd0, o.sr}, 32'd1);
    endtask

    vec_t tbl[10];

    initial begin
        obs_t o;
        logic [31:0] mr;
        logic mc, mv, mz;
        int n;

        tbl[0] = '{0, 32'h0000000F, 32'h00000001, 0, 32'h00000010, 0, 0, 0, "carry chain 32"};
        tbl[1] = '{0, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 1, 0, 1, "wrap 32"};
        tbl[2] = '{0, 32'h7FFFFFFF, 32'hFFFFFFFF, 1, 32'h80000000, 0, 1, 0, "sub ovf 32"};
        tbl[3] = '{0, 32'h00000005, 32'h00000005, 1, 32'h00000000, 1, 0, 1, "sub zero 32"};
        tbl[4] = '{0, 32'h12345678, 32'h11111111, 0, 32'h23456789, 0, 0, 0, "add 32"};
        tbl[5] = '{1, 32'h0F, 32'h01, 0, 32'h10, 0, 0, 0, "carry chain 8"};
        tbl[6] = '{1, 32'hFF, 32'h01, 0, 32'h00, 1, 0, 1, "wrap 8"};
        tbl[7] = '{1, 32'h7F, 32'hFF, 1, 32'h80, 0, 1, 0, "sub ovf 8"};
        tbl[8] = '{1, 32'h05, 32'h05, 1, 32'h00, 1, 0, 1, "sub zero 8"};
        tbl[9] = '{1, 32'h78, 32'h11, 0, 32'h89, 0, 1, 0, "add ovf 8"};

        // Reset with junk on the inputs.
        set_in(0, 1'b1, $urandom, $urandom, 1'b1);
        set_in(1, 1'b1, $urandom, $urandom, 1'b0);
        rr32 = 1'b1; rr8 = 1'b1;
        tick(); tick(); tick();
        for (int w = 0; w < 2; w++) begin
            o = get(w[0]);
            chk("reset res_valid", {31'd0, o.rv}, 32'd0);
            chk("reset busy", {31'd0, o.busy}, 32'd0);
            chk("reset result", o.res, 32'd0);
            chk("reset flags", {29'd0, o.c, o.v, o.z}, 32'd0);
        end
        set_in(0, 1'b0, 0, 0, 0);
        set_in(1, 1'b0, 0, 0, 0);
        rr32 = 1'b0; rr8 = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("start_ready after reset 32", {31'd0, sr32}, 32'd1);
        chk("start_ready after reset 8", {31'd0, sr8}, 32'd1);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            accept(tbl[i].w8, tbl[i].a, tbl[i].b, tbl[i].s);
            collect(tbl[i].w8, tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].z, tbl[i].nm, 0);
        end

        // Backpressure with a competing request held on the inputs.
        accept(0, 32'h3, 32'h4, 0);
        n = 0;
        while (!rv32 && n < 100) begin tick(); n++; end
        chk("bp latency", n, 8);
        set_in(0, 1'b1, 32'hA5A50000, 32'h00005A5A, 0);
        for (int h = 0; h < 5; h++) begin
            tick();
            chk("bp valid held", {31'd0, rv32}, 32'd1);
            chk("bp start_ready low", {31'd0, sr32}, 32'd0);
            chk("bp result stable", res32, 32'h7);
            chk("bp flags stable", {29'd0, c32, v32, z32}, 32'd0);
        end
        rr32 = 1'b1;
        tick();
        rr32 = 1'b0;
        chk("bp no accept on handshake", {31'd0, bz32}, 32'd0);
        chk("bp ready after handshake", {31'd0, sr32}, 32'd1);
        tick();
        chk("bp accepted next cycle", {31'd0, bz32}, 32'd1);
        set_in(0, 1'b0, 0, 0, 0);
        collect(0, 32'hA5A55A5A, 0, 0, 0, "bp new op", 0);

        // Reset during the 4th RUN cycle.
        accept(0, $urandom, $urandom, 0);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #2;
        chk("mid-run reset valid", {31'd0, rv32}, 32'd0);
        chk("mid-run reset busy", {31'd0, bz32}, 32'd0);
        chk("mid-run reset result", res32, 32'd0);
        chk("mid-run reset flags", {29'd0, c32, v32, z32}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("ready after mid-run reset", {31'd0, sr32}, 32'd1);
        n = 0;
        for (int h = 0; h < 12; h++) begin tick(); n += rv32; end
        chk("no result after mid-run reset", n, 0);
        accept(0, 32'h12345678, 32'h11111111, 0);
        collect(0, 32'h23456789, 0, 0, 0, "post-reset add", 0);

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            bit w8;
            logic [31:0] ra, rb;
            logic rs;
            w8 = 1'($urandom_range(1));
            ra = $urandom;
            rb = (i % 5 == 0) ? ra : $urandom;
            rs = 1'($urandom_range(1));
            model(w8, ra, rb, rs, mr, mc, mv, mz);
            accept(w8, ra, rb, rs);
            collect(w8, mr, mc, mv, mz, "random", $urandom_range(2));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
